log_wr_arb: RTL and testbench
=============================

LOG_WR_ARB -- requirements
Module: log_wr_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning log memory address width; the log holds 2^ADDR_W beats.
REQ-002 SHALL have parameter LEN_W, default 6, meaning entry length field width in beats.
REQ-003 SHALL have ports, one per line, as name, direction, width, meaning:
- clk  in  1  sole clock; all logic on posedge clk.
- rst  in  1  synchronous, active-high reset.
- src_req_val  in  2  requester i wants to write one log entry.
- src_req_len  in  2*LEN_W  entry length in beats; requester i occupies bits [i*LEN_W +: LEN_W].
- arb_src_grant  out  2  one-cycle grant pulse to requester i.
- src_wr_val  in  2  data beat valid from requester i.
- src_wr_last  in  2  requester i marks its final beat.
- arb_src_wr_rdy  out  2  beat accepted from requester i.
- arb_mem_wr_val  out  1  write to the log data memory.
- arb_mem_wr_addr  out  ADDR_W  log write address.
- arb_mem_wr_src  out  1  index of the requester owning the current beat.
- mem_arb_wr_rdy  in  1  log memory accepts the write.
- log_free_val  in  1  consumer releases log space.
- log_free_len  in  LEN_W  number of beats released.
- log_used  out  ADDR_W+1  beats reserved or occupied.
- arb_err  out  1  sticky protocol-error flag.

Function
REQ-004 SHALL implement FSM states IDLE and XFER.
REQ-005 SHALL select the IDLE winner as follows: the only valid requester; if both are valid, the requester equal to rr_prio.
REQ-006 SHALL, in IDLE, assert arb_src_grant[w] combinationally in the same cycle when src_req_len[w] <= 2^ADDR_W - log_used. The check uses registered log_used, before any same-cycle free.
REQ-007 SHALL NOT grant the other requester when the winner lacks space; the arbiter stalls on the winner to prevent starvation.
REQ-008 SHALL, on grant, do all of the following: latch the owner and length, add the length to log_used, set rr_prio to 1-w, and go to XFER next cycle.
REQ-009 SHALL treat a grant with length 0 as complete: it reserves nothing and stays in IDLE.
REQ-010 SHALL, in XFER, drive the memory write from the owner only:
- arb_mem_wr_val = src_wr_val[owner];
- arb_src_wr_rdy[owner] = mem_arb_wr_rdy;
- the non-owner's arb_src_wr_rdy = 0;
- arb_mem_wr_addr = wr_ptr;
- arb_mem_wr_src = owner.
REQ-011 SHALL, on each XFER handshake (src_wr_val[owner] & mem_arb_wr_rdy), increment wr_ptr modulo 2^ADDR_W and increment beat_cnt.
REQ-012 SHALL end the entry when beat_cnt reaches the latched length: the handshake on beat len-1 moves the FSM to IDLE. src_wr_last does not terminate the entry.
REQ-013 SHALL set arb_err when src_wr_last[owner] mismatches on a handshake beat, i.e. last asserted on a beat other than len-1, or deasserted on beat len-1.
REQ-014 SHALL update log_used_next = log_used + reserve - free, where reserve and free are both applied when they occur in the same cycle.
REQ-015 SHALL clamp log_used to 0 and set arb_err when a free exceeds the post-reserve occupancy.
REQ-016 SHALL drive arb_src_grant = 0 in XFER and arb_mem_wr_val = 0 in IDLE.
REQ-017 SHALL hold arb_err until reset.

Reset
REQ-018 SHALL, on rst, force the following:
- state = IDLE;
- wr_ptr, beat_cnt, log_used, rr_prio and arb_err = 0;
- all grant, rdy and mem outputs = 0.
REQ-019 SHALL abort an in-progress XFER on rst, with no memory write in the cycle after rst is sampled, and SHALL NOT retain the reservation.

Verification
REQ-020 SHALL cover the single-requester case:
- stimulus: after reset, req0 with len 3, rdy=1, beats back-to-back with last on beat 2;
- response: grant[0] in cycle 0; addresses 0,1,2 in cycles 1-3; log_used=3 from cycle 1; return to IDLE in cycle 4.
REQ-021 SHALL cover the simultaneous-request case:
- stimulus: after reset, req0 and req1 with len 2 in the same cycle;
- response: req0 granted first at addresses 0,1; req1 granted next at addresses 2,3; log_used=4.
REQ-022 SHALL cover the full-log case:
- stimulus: ADDR_W=4, log_used=14, req len 3;
- response: no grant; after log_free_val with len 2, grant asserted in the following cycle with log_used=15.
REQ-023 SHALL cover address wrap-around:
- stimulus: wr_ptr=14 with ADDR_W=4, len 4;
- response: addresses 14,15,0,1; wr_ptr=2 afterwards.
REQ-024 SHALL cover the length-mismatch case:
- stimulus: len 4 with last asserted on beat 1;
- response: arb_err=1 and sticky; all 4 beats still written; FSM returns to IDLE after beat 3.
REQ-025 SHALL cover reset mid-transfer:
- stimulus: rst asserted during beat 1 of len 4;
- response: arb_mem_wr_val=0 next cycle; log_used=0; wr_ptr=0.

Source files
------------

// File: rtl/log_wr_arb.sv
// Two-requester write arbiter for a circular log memory: reserves space per entry,
// streams the owner's beats into the log and tracks occupancy against consumer frees.
module log_wr_arb #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            src_req_val,
  input  logic [2*LEN_W-1:0]    src_req_len,
  output logic [1:0]            arb_src_grant,
  input  logic [1:0]            src_wr_val,
  input  logic [1:0]            src_wr_last,
  output logic [1:0]            arb_src_wr_rdy,
  output logic                  arb_mem_wr_val,
  output logic [ADDR_W-1:0]     arb_mem_wr_addr,
  output logic                  arb_mem_wr_src,
  input  logic                  mem_arb_wr_rdy,
  input  logic                  log_free_val,
  input  logic [LEN_W-1:0]      log_free_len,
  output logic [ADDR_W:0]       log_used,
  output logic                  arb_err
);

  localparam int UW = ADDR_W + 1;
  localparam int CW = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 2;

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t             state;
  state_t             state_next;
  logic               owner;
  logic [LEN_W-1:0]   len_q;
  logic [ADDR_W-1:0]  wr_ptr;
  logic [LEN_W-1:0]   beat_cnt;
  logic               rr_prio;

  logic               winner;
  logic [LEN_W-1:0]   win_len;
  logic [CW-1:0]      space;
  logic               do_grant;
  logic               hs;
  logic               last_beat;
  logic               mismatch;
  logic [CW-1:0]      post;
  logic               over;
  logic [CW-1:0]      used_next;

  // Winner selection and space check against the registered occupancy.
  always_comb begin
    if (src_req_val == 2'b11) begin
      winner = rr_prio;
    end else begin
      winner = src_req_val[1];
    end
    win_len  = winner ? src_req_len[LEN_W +: LEN_W] : src_req_len[0 +: LEN_W];
    space    = (CW'(1) << ADDR_W) - CW'(log_used);
    do_grant = (state == IDLE) && (|src_req_val) && (CW'(win_len) <= space) && !rst;
  end

  // Beat handshake, end-of-entry detection and last-flag consistency.
  always_comb begin
    hs        = (state == XFER) && src_wr_val[owner] && mem_arb_wr_rdy;
    last_beat = (beat_cnt == LEN_W'(len_q - LEN_W'(1)));
    mismatch  = hs && (src_wr_last[owner] != last_beat);
  end

  // Occupancy update: reserve and free in the same cycle, clamping on over-free.
  always_comb begin
    post = CW'(log_used) + (do_grant ? CW'(win_len) : CW'(0));
    over = log_free_val && (CW'(log_free_len) > post);
    if (!log_free_val) begin
      used_next = post;
    end else if (over) begin
      used_next = CW'(0);
    end else begin
      used_next = post - CW'(log_free_len);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a zero-length grant completes without a transfer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (do_grant && (win_len != LEN_W'(0))) begin
          state_next = XFER;
        end else begin
          state_next = IDLE;
        end
      end
      XFER: begin
        if (hs && last_beat) begin
          state_next = IDLE;
        end else begin
          state_next = XFER;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs; everything is held low while reset is asserted.
  always_comb begin
    arb_src_grant   = 2'b00;
    arb_src_wr_rdy  = 2'b00;
    arb_mem_wr_val  = 1'b0;
    arb_mem_wr_addr = '0;
    arb_mem_wr_src  = 1'b0;
    if (rst) begin
      arb_src_grant = 2'b00;
    end else begin
      case (state)
        IDLE: arb_src_grant[winner] = do_grant;
        XFER: begin
          arb_mem_wr_val        = src_wr_val[owner];
          arb_src_wr_rdy[owner] = mem_arb_wr_rdy;
          arb_mem_wr_addr       = wr_ptr;
          arb_mem_wr_src        = owner;
        end
        default: arb_src_grant = 2'b00;
      endcase
    end
  end

  // Datapath registers: ownership, pointers, occupancy and the sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner    <= 1'b0;
      len_q    <= '0;
      wr_ptr   <= '0;
      beat_cnt <= '0;
      log_used <= '0;
      rr_prio  <= 1'b0;
      arb_err  <= 1'b0;
    end else begin
      log_used <= used_next[UW-1:0];
      if (over || mismatch) begin
        arb_err <= 1'b1;
      end
      if (do_grant) begin
        owner    <= winner;
        len_q    <= win_len;
        rr_prio  <= ~winner;
        beat_cnt <= '0;
      end
      if (hs) begin
        wr_ptr   <= wr_ptr + ADDR_W'(1);
        beat_cnt <= last_beat ? LEN_W'(0) : beat_cnt + LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_log_wr_arb.sv
// Directed, table-driven bench for log_wr_arb (ADDR_W=4 so full-log and wrap cases are short).
module tb_log_wr_arb;

  logic        clk;
  logic        rst;
  logic [1:0]  src_req_val;
  logic [11:0] src_req_len;
  logic [1:0]  arb_src_grant;
  logic [1:0]  src_wr_val;
  logic [1:0]  src_wr_last;
  logic [1:0]  arb_src_wr_rdy;
  logic        arb_mem_wr_val;
  logic [3:0]  arb_mem_wr_addr;
  logic        arb_mem_wr_src;
  logic        mem_arb_wr_rdy;
  logic        log_free_val;
  logic [5:0]  log_free_len;
  logic [4:0]  log_used;
  logic        arb_err;

  int checks = 0;
  int errors = 0;

  log_wr_arb #(.ADDR_W(4), .LEN_W(6)) dut (
    .clk(clk), .rst(rst),
    .src_req_val(src_req_val), .src_req_len(src_req_len),
    .arb_src_grant(arb_src_grant),
    .src_wr_val(src_wr_val), .src_wr_last(src_wr_last),
    .arb_src_wr_rdy(arb_src_wr_rdy),
    .arb_mem_wr_val(arb_mem_wr_val), .arb_mem_wr_addr(arb_mem_wr_addr),
    .arb_mem_wr_src(arb_mem_wr_src), .mem_arb_wr_rdy(mem_arb_wr_rdy),
    .log_free_val(log_free_val), .log_free_len(log_free_len),
    .log_used(log_used), .arb_err(arb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [1:0] rv;
    logic [5:0] l0;
    logic [5:0] l1;
    logic [1:0] wv;
    logic [1:0] wl;
    logic       mr;
    logic       fv;
    logic [5:0] fl;
    logic [1:0] g;
    logic [1:0] rdy;
    logic       mv;
    logic [3:0] ma;
    logic       ms;
    logic [4:0] lu;
    logic       er;
  } vec_t;

  function automatic vec_t V(input logic rs, input logic [1:0] rv, input logic [5:0] l0,
                             input logic [5:0] l1, input logic [1:0] wv, input logic [1:0] wl,
                             input logic mr, input logic fv, input logic [5:0] fl,
                             input logic [1:0] g, input logic [1:0] rdy, input logic mv,
                             input logic [3:0] ma, input logic ms, input logic [4:0] lu,
                             input logic er);
    vec_t v;
    v.rs = rs; v.rv = rv; v.l0 = l0; v.l1 = l1; v.wv = wv; v.wl = wl;
    v.mr = mr; v.fv = fv; v.fl = fl; v.g = g; v.rdy = rdy; v.mv = mv;
    v.ma = ma; v.ms = ms; v.lu = lu; v.er = er;
    return v;
  endfunction

  // Apply one cycle of inputs just after posedge, compare at negedge.
  task automatic run(input vec_t v, input string nm);
    logic [15:0] act;
    logic [15:0] exp;
    rst            = v.rs;
    src_req_val    = v.rv;
    src_req_len    = {v.l1, v.l0};
    src_wr_val     = v.wv;
    src_wr_last    = v.wl;
    mem_arb_wr_rdy = v.mr;
    log_free_val   = v.fv;
    log_free_len   = v.fl;
    @(negedge clk);
    act = {arb_src_grant, arb_src_wr_rdy, arb_mem_wr_val, arb_mem_wr_addr,
           arb_mem_wr_src, log_used, arb_err};
    exp = {v.g, v.rdy, v.mv, v.ma, v.ms, v.lu, v.er};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got g/rdy/mv/ma/ms/lu/er=%b/%b/%b/%0d/%b/%0d/%b want %b/%b/%b/%0d/%b/%0d/%b",
               nm, arb_src_grant, arb_src_wr_rdy, arb_mem_wr_val, arb_mem_wr_addr,
               arb_mem_wr_src, log_used, arb_err, v.g, v.rdy, v.mv, v.ma, v.ms, v.lu, v.er);
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[15];
  logic [1:0] wl_k;

  initial begin
    rst = 1'b1; src_req_val = 2'b00; src_req_len = 12'd0; src_wr_val = 2'b00;
    src_wr_last = 2'b00; mem_arb_wr_rdy = 1'b0; log_free_val = 1'b0; log_free_len = 6'd0;
    @(posedge clk);
    #1;

    // Reset state, single requester, simultaneous requests with a memory stall.
    tbl[0]  = V(1'b1, 2'b00, 6'd0, 6'd0, 2'b00, 2'b00, 1'b0, 1'b0, 6'd0, 2'b00, 2'b00, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0);
    tbl[1]  = V(1'b0, 2'b01, 6'd3, 6'd0, 2'b00, 2'b00, 1'b1, 1'b0, 6'd0, 2'b01, 2'b00, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0);
    tbl[2]  = V(1'b0, 2'b00, 6'd0, 6'd0, 2'b01, 2'b00, 1'b1, 1'b0, 6'd0, 2'b00, 2'b01, 1'b1, 4'd0, 1'b0, 5'd3, 1'b0);
    tbl[3]  = V(1'b0, 2'b00, 6'd0, 6'd0, 2'b01, 2'b00, 1'b1, 1'b0, 6'd0, 2'b00, 2'b01, 1'b1, 4'd1, 1'b0, 5'd3, 1'b0);
    tbl[4]  = V(1'b0, 2'b00, 6'd0, 6'd0, 2'b01, 2'b01, 1'b1, 1'b0, 6'd0, 2'b00, 2'b01, 1'b1, 4'd2, 1'b0, 5'd3, 1'b0);
    tbl[5]  = V(1'b0, 2'b00, 6'd0, 6'd0, 2'b00, 2'b00, 1'b1, 1'b1, 6'd3, 2'b00, 2'b00, 1'b0, 4'd0, 1'b0, 5'd3, 1'b0);
    tbl[6]  = V(1'b1, 2'b00, 6'd0, 6'd0, 2'b00, 2'b00, 1'b1, 1'b0, 6'd0, 2'b00, 2'b00, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0);
    tbl[7]  = V(1'b0, 2'b11, 6'd2, 6'd2, 2'b00, 2'b00, 1'b1, 1'b0, 6'd0, 2'b01, 2'b00, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0);
    tbl[8]  = V(1'b0, 2'b10, 6'd2, 6'd2, 2'b11, 2'b00, 1'b1, 1'b0, 6'd0, 2'b00, 2'b01, 1'b1, 4'd0, 1'b0, 5'd2, 1'b0);
    tbl[9]  = V(1'b0, 2'b10, 6'd2, 6'd2, 2'b11, 2'b11, 1'b1, 1'b0, 6'd0, 2'b00, 2'b01, 1'b1, 4'd1, 1'b0, 5'd2, 1'b0);
    tbl[10] = V(1'b0, 2'b10, 6'd2, 6'd2, 2'b00, 2'b00, 1'b1, 1'b0, 6'd0, 2'b10, 2'b00, 1'b0, 4'd0, 1'b0, 5'd2, 1'b0);
    tbl[11] = V(1'b0, 2'b00, 6'd0, 6'd0, 2'b10, 2'b00, 1'b0, 1'b0, 6'd0, 2'b00, 2'b00, 1'b1, 4'd2, 1'b1, 5'd4, 1'b0);
    tbl[12] = V(1'b0, 2'b00, 6'd0, 6'd0, 2'b10, 2'b00, 1'b1, 1'b0, 6'd0, 2'b00, 2'b10, 1'b1, 4'd2, 1'b1, 5'd4, 1'b0);
    tbl[13] = V(1'b0, 2'b00, 6'd0, 6'd0, 2'b10, 2'b10, 1'b1, 1'b0, 6'd0, 2'b00, 2'b10, 1'b1, 4'd3, 1'b1, 5'd4, 1'b0);
    tbl[14] = V(1'b0, 2'b00, 6'd0, 6'd0, 2'b00, 2'b00, 1'b1, 1'b1, 6'd4, 2'b00, 2'b00, 1'b0, 4'd0, 1'b0, 5'd4, 1'b0);
    for (int i = 0; i < 15; i++) run(tbl[i], $sformatf("tbl%0d", i));

    // Advance wr_ptr to 14, then a length-4 entry that wraps and carries a bad last flag.
    run(V(1'b0, 2'b01, 6'd10, 6'd0, 2'b00, 2'b00, 1'b1, 1'b0, 6'd0, 2'b01, 2'b00, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0), "fill_grant");
    for (int k = 0; k < 10; k++) begin
      wl_k = (k == 9) ? 2'b01 : 2'b00;
      run(V(1'b0, 2'b00, 6'd0, 6'd0, 2'b01, wl_k, 1'b1, 1'b0, 6'd0, 2'b00, 2'b01, 1'b1, 4'(4 + k), 1'b0, 5'd10, 1'b0), $sformatf("fill_beat%0d", k));
    end
    run(V(1'b0, 2'b00, 6'd0, 6'd0, 2'b00, 2'b00, 1'b1, 1'b1, 6'd10, 2'b00, 2'b00, 1'b0, 4'd0, 1'b0, 5'd10, 1'b0), "fill_free");
    run(V(1'b0, 2'b10, 6'd0, 6'd4, 2'b00, 2'b00, 1'b1, 1'b0, 6'd0, 2'b10, 2'b00, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0), "wrap_grant");
    for (int k = 0; k < 4; k++) begin
      wl_k = (k == 1) ? 2'b10 : 2'b00;
      run(V(1'b0, 2'b00, 6'd0, 6'd0, 2'b10, wl_k, 1'b1, 1'b0, 6'd0, 2'b00, 2'b10, 1'b1, 4'(14 + k), 1'b1, 5'd4, (k >= 2) ? 1'b1 : 1'b0), $sformatf("wrap_beat%0d", k));
    end
    run(V(1'b0, 2'b00, 6'd0, 6'd0, 2'b10, 2'b00, 1'b1, 1'b0, 6'd0, 2'b00, 2'b00, 1'b0, 4'd0, 1'b0, 5'd4, 1'b1), "wrap_idle_sticky");

    // Fill to 14 of 16; the round-robin winner (req1, len 3) stalls until 2 beats are freed.
    run(V(1'b0, 2'b01, 6'd10, 6'd0, 2'b00, 2'b00, 1'b1, 1'b0, 6'd0, 2'b01, 2'b00, 1'b0, 4'd0, 1'b0, 5'd4, 1'b1), "full_grant");
    for (int k = 0; k < 10; k++) begin
      wl_k = (k == 9) ? 2'b01 : 2'b00;
      run(V(1'b0, 2'b00, 6'd0, 6'd0, 2'b01, wl_k, 1'b1, 1'b0, 6'd0, 2'b00, 2'b01, 1'b1, 4'(2 + k), 1'b0, 5'd14, 1'b1), $sformatf("full_beat%0d", k));
    end
    run(V(1'b0, 2'b11, 6'd1, 6'd3, 2'b00, 2'b00, 1'b1, 1'b0, 6'd0, 2'b00, 2'b00, 1'b0, 4'd0, 1'b0, 5'd14, 1'b1), "full_stall0");
    run(V(1'b0, 2'b11, 6'd1, 6'd3, 2'b00, 2'b00, 1'b1, 1'b0, 6'd0, 2'b00, 2'b00, 1'b0, 4'd0, 1'b0, 5'd14, 1'b1), "full_stall1");
    run(V(1'b0, 2'b11, 6'd1, 6'd3, 2'b00, 2'b00, 1'b1, 1'b1, 6'd2, 2'b00, 2'b00, 1'b0, 4'd0, 1'b0, 5'd14, 1'b1), "full_free");
    run(V(1'b0, 2'b11, 6'd1, 6'd3, 2'b00, 2'b00, 1'b1, 1'b0, 6'd0, 2'b10, 2'b00, 1'b0, 4'd0, 1'b0, 5'd12, 1'b1), "full_grant_late");
    for (int k = 0; k < 3; k++) begin
      wl_k = (k == 2) ? 2'b10 : 2'b00;
      run(V(1'b0, 2'b00, 6'd0, 6'd0, 2'b10, wl_k, 1'b1, 1'b0, 6'd0, 2'b00, 2'b10, 1'b1, 4'(12 + k), 1'b1, 5'd15, 1'b1), $sformatf("full_beat_b%0d", k));
    end

    // Reset during beat 1 of a length-4 entry.
    run(V(1'b0, 2'b00, 6'd0, 6'd0, 2'b00, 2'b00, 1'b1, 1'b1, 6'd15, 2'b00, 2'b00, 1'b0, 4'd0, 1'b0, 5'd15, 1'b1), "rst_free_all");
    run(V(1'b0, 2'b01, 6'd4, 6'd0, 2'b00, 2'b00, 1'b1, 1'b0, 6'd0, 2'b01, 2'b00, 1'b0, 4'd0, 1'b0, 5'd0, 1'b1), "rst_grant");
    run(V(1'b0, 2'b00, 6'd0, 6'd0, 2'b01, 2'b00, 1'b1, 1'b0, 6'd0, 2'b00, 2'b01, 1'b1, 4'd15, 1'b0, 5'd4, 1'b1), "rst_beat0");
    run(V(1'b1, 2'b00, 6'd0, 6'd0, 2'b01, 2'b00, 1'b1, 1'b0, 6'd0, 2'b00, 2'b00, 1'b0, 4'd0, 1'b0, 5'd4, 1'b1), "rst_beat1");
    run(V(1'b0, 2'b00, 6'd0, 6'd0, 2'b01, 2'b00, 1'b1, 1'b0, 6'd0, 2'b00, 2'b00, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0), "rst_after");
    run(V(1'b0, 2'b01, 6'd1, 6'd0, 2'b00, 2'b00, 1'b1, 1'b0, 6'd0, 2'b01, 2'b00, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0), "rst_regrant");
    run(V(1'b0, 2'b00, 6'd0, 6'd0, 2'b01, 2'b01, 1'b1, 1'b0, 6'd0, 2'b00, 2'b01, 1'b1, 4'd0, 1'b0, 5'd1, 1'b0), "rst_ptr_zero");

    // Zero-length grants stay in IDLE; then an over-free clamps and flags.
    run(V(1'b0, 2'b01, 6'd0, 6'd0, 2'b00, 2'b00, 1'b1, 1'b0, 6'd0, 2'b01, 2'b00, 1'b0, 4'd0, 1'b0, 5'd1, 1'b0), "zero_len0");
    run(V(1'b0, 2'b01, 6'd0, 6'd0, 2'b00, 2'b00, 1'b1, 1'b0, 6'd0, 2'b01, 2'b00, 1'b0, 4'd0, 1'b0, 5'd1, 1'b0), "zero_len1");
    run(V(1'b0, 2'b00, 6'd0, 6'd0, 2'b00, 2'b00, 1'b1, 1'b1, 6'd3, 2'b00, 2'b00, 1'b0, 4'd0, 1'b0, 5'd1, 1'b0), "overfree");
    run(V(1'b0, 2'b00, 6'd0, 6'd0, 2'b00, 2'b00, 1'b1, 1'b0, 6'd0, 2'b00, 2'b00, 1'b0, 4'd0, 1'b0, 5'd0, 1'b1), "overfree_clamp");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
